control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Synthesizable control unit that replaces the fixed T0–T5 stimulus sequencing used for single-instruction datapath bring-up.
- Fetches, decodes and executes three-register ALU instructions in a loop, driving one-hot register in/out selects and datapath strobes.
- Sits beside the datapath; consumes the IR contents and a memory-ready handshake.

Parameters:
- NUM_REGS, 16, number of general registers; width of the one-hot r_in/r_out vectors (power of 2, ≤16).
- OPCODE_W, 5, opcode field width, IR[31:31-OPCODE_W+1].
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous, active-high reset.
- run  in  1  level; sequencer leaves IDLE and keeps looping while high.
- ir  in  32  instruction register contents from the datapath.
- mem_ready  in  1  memory read data valid (fetch handshake).
- pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in  out  1 each  datapath strobes.
- r_in  out  NUM_REGS  one-hot register load select.
- r_out  out  NUM_REGS  one-hot register drive select.
- alu_op  out  3  ALU function: 0 pass, 1 ADD, 2 SUB, 3 AND, 4 OR.
- busy  out  1  high in any state except IDLE and HALTED.
- halted  out  1  high in HALTED.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- instr_count  out  CNT_W  instructions retired; wraps to 0.

Behaviour:
- Reset: clear=1 at a rising edge forces state IDLE and instr_count=0, from any state including mid-instruction and mid-wait. All strobes, r_in, r_out, alu_op, busy, halted and illegal read 0 in IDLE.
- Decode fields: opcode=IR[31:27], ra=IR[26:23] (destination), rb=IR[22:19], rc=IR[18:15]. Register indices ≥ NUM_REGS select nothing (all-zero vector).
- Opcodes: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00000 NOP, 11111 HALT. All others are illegal.
- Strobes are Moore outputs of state, except in T1 (see below).
- IDLE: when run=1 → T0; otherwise stay.
- T0: pc_out, mar_in, inc_pc, z_in → T1.
- T1: read and mdr_in held high every cycle. zlow_out and pc_in assert only in the cycle mem_ready=1, which also moves to T2. With mem_ready=0, stay in T1 indefinitely.
- T2: mdr_out, ir_in → T3. IR is valid from T3 on.
- T3 decode:
  - ALU op: r_out[rb], y_in → T4.
  - NOP: instr_count+1, → T0 if run else IDLE.
  - HALT: → HALTED.
  - illegal: illegal=1 for this cycle, count unchanged, → T0 if run else IDLE.
- T4: r_out[rc], alu_op per opcode, z_in → T5.
- T5: zlow_out, r_in[ra]; instr_count+1 at the exit edge → T0 if run else IDLE.
- HALTED: halted=1; only clear exits. run is ignored.
- run deassertion is sampled only at instruction boundaries; an in-flight instruction always completes.
- At most one bit of r_in and one bit of r_out is ever set. r_in and r_out are never both nonzero in the same cycle.
- Latency: ALU instruction = 6 cycles + (mem_ready wait cycles); NOP/illegal = 4 + wait.

Decomposition:
- Package cpu_ctrl_pkg:
  - state enum: IDLE, T0–T5, HALTED.
  - opcode constants.
  - alu_op constants.
  - IR field bit positions.
- Sub-module instr_decode: combinational; ir → opcode class, alu_op, one-hot ra/rb/rc vectors.

Test Plan:
- Reset mid-wait: clear=1 while in T1 with mem_ready=0 → next cycle IDLE, all outputs 0, instr_count=0.
- AND fetch/execute: run=1, mem_ready=1 always, ir=32'h28918000. T3 → r_out=16'h0004 with y_in. T4 → r_out=16'h0008, alu_op=3, z_in. T5 → r_in=16'h0002 with zlow_out. instr_count=1 after 6 cycles.
- Memory stall: mem_ready low for 3 cycles in T1 → read/mdr_in held 4 cycles; pc_in asserted exactly once; instruction completes in 9 cycles.
- Illegal then NOP: ir opcode 01010 → illegal pulses once at T3, count unchanged. Then ir=32'h00000000 → count increments, no r_in activity.
- HALT: ir opcode 11111 → halted=1, busy=0 for 20 cycles regardless of run; clear returns to IDLE.
- Counter wrap with CNT_W=2: 5 consecutive NOPs → instr_count sequence 1,2,3,0,1. run dropped during the 5th → IDLE after it retires.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and constants for the control sequencer:
//                FSM states, opcode classes, opcode/ALU encodings and the
//                instruction-register field layout.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

   // Sequencer states; T0..T5 are the micro-steps of one instruction
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_T0     = 3'd1,
      ST_T1     = 3'd2,
      ST_T2     = 3'd3,
      ST_T3     = 3'd4,
      ST_T4     = 3'd5,
      ST_T5     = 3'd6,
      ST_HALTED = 3'd7
   } state_t;

   // Coarse decode result used by the T3 dispatch
   typedef enum logic [1:0] {
      CLS_ALU     = 2'd0,
      CLS_NOP     = 2'd1,
      CLS_HALT    = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_t;

   // Opcode encodings
   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_HALT = 5'b11111;

   // ALU function encodings
   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;

   // Instruction register field layout
   localparam int IR_OPC_MSB  = 31;
   localparam int IR_RA_LSB   = 23;
   localparam int IR_RB_LSB   = 19;
   localparam int IR_RC_LSB   = 15;
   localparam int REG_FIELD_W = 4;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational decode of the instruction register into an
//                opcode class, ALU function and one-hot register selects.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int OPCODE_W = 5
) (
   input  logic [31:0]         ir,
   output op_class_t           op_class,
   output logic [2:0]          alu_op,
   output logic [NUM_REGS-1:0] ra_oh,
   output logic [NUM_REGS-1:0] rb_oh,
   output logic [NUM_REGS-1:0] rc_oh
);

   logic [OPCODE_W-1:0]    opcode;
   logic [REG_FIELD_W-1:0] ra_idx;
   logic [REG_FIELD_W-1:0] rb_idx;
   logic [REG_FIELD_W-1:0] rc_idx;
   logic                   unused_ir_bits;

   assign opcode = ir[IR_OPC_MSB -: OPCODE_W];
   assign ra_idx = ir[IR_RA_LSB +: REG_FIELD_W];
   assign rb_idx = ir[IR_RB_LSB +: REG_FIELD_W];
   assign rc_idx = ir[IR_RC_LSB +: REG_FIELD_W];
   assign unused_ir_bits = ^ir[IR_RC_LSB-1:0];

   // Classify the opcode and select the ALU function
   always_comb begin
      op_class = CLS_ILLEGAL;
      alu_op   = ALU_PASS;
      case (opcode)
         OPCODE_W'(OP_ADD):  begin op_class = CLS_ALU; alu_op = ALU_ADD; end
         OPCODE_W'(OP_SUB):  begin op_class = CLS_ALU; alu_op = ALU_SUB; end
         OPCODE_W'(OP_AND):  begin op_class = CLS_ALU; alu_op = ALU_AND; end
         OPCODE_W'(OP_OR):   begin op_class = CLS_ALU; alu_op = ALU_OR;  end
         OPCODE_W'(OP_NOP):  op_class = CLS_NOP;
         OPCODE_W'(OP_HALT): op_class = CLS_HALT;
         default:            op_class = CLS_ILLEGAL;
      endcase
   end

   // One-hot register selects; indices beyond NUM_REGS match no bit
   always_comb begin
      ra_oh = '0;
      rb_oh = '0;
      rc_oh = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         ra_oh[i] = (ra_idx == REG_FIELD_W'(i));
         rb_oh[i] = (rb_idx == REG_FIELD_W'(i));
         rc_oh[i] = (rc_idx == REG_FIELD_W'(i));
      end
   end

endmodule : instr_decode
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Fetch/decode/execute sequencer for three-register ALU
//                instructions. Drives datapath strobes and one-hot register
//                selects, counts retired instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int OPCODE_W = 5,
   parameter int CNT_W    = 16
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                run,
   input  logic [31:0]         ir,
   input  logic                mem_ready,
   output logic                pc_out,
   output logic                mar_in,
   output logic                inc_pc,
   output logic                z_in,
   output logic                zlow_out,
   output logic                pc_in,
   output logic                read,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                ir_in,
   output logic                y_in,
   output logic [NUM_REGS-1:0] r_in,
   output logic [NUM_REGS-1:0] r_out,
   output logic [2:0]          alu_op,
   output logic                busy,
   output logic                halted,
   output logic                illegal,
   output logic [CNT_W-1:0]    instr_count
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   op_class_t           dec_class;
   logic [2:0]          dec_alu_op;
   logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;

   instr_decode #(
      .NUM_REGS (NUM_REGS),
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .ir       (ir),
      .op_class (dec_class),
      .alu_op   (dec_alu_op),
      .ra_oh    (ra_oh),
      .rb_oh    (rb_oh),
      .rc_oh    (rc_oh)
   );

   // Next-state, counter update and state-decoded strobes; only T1 looks at mem_ready
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pc_out   = 1'b0;
      mar_in   = 1'b0;
      inc_pc   = 1'b0;
      z_in     = 1'b0;
      zlow_out = 1'b0;
      pc_in    = 1'b0;
      read     = 1'b0;
      mdr_in   = 1'b0;
      mdr_out  = 1'b0;
      ir_in    = 1'b0;
      y_in     = 1'b0;
      r_in     = '0;
      r_out    = '0;
      alu_op   = ALU_PASS;
      halted   = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_T0;
         end
         ST_T0: begin
            pc_out  = 1'b1;
            mar_in  = 1'b1;
            inc_pc  = 1'b1;
            z_in    = 1'b1;
            state_d = ST_T1;
         end
         ST_T1: begin
            read   = 1'b1;
            mdr_in = 1'b1;
            if (mem_ready) begin
               zlow_out = 1'b1;
               pc_in    = 1'b1;
               state_d  = ST_T2;
            end
         end
         ST_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
            state_d = ST_T3;
         end
         ST_T3: begin
            case (dec_class)
               CLS_ALU: begin
                  r_out   = rb_oh;
                  y_in    = 1'b1;
                  state_d = ST_T4;
               end
               CLS_NOP: begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = run ? ST_T0 : ST_IDLE;
               end
               CLS_HALT: begin
                  state_d = ST_HALTED;
               end
               default: begin
                  illegal = 1'b1;
                  state_d = run ? ST_T0 : ST_IDLE;
               end
            endcase
         end
         ST_T4: begin
            r_out   = rc_oh;
            alu_op  = dec_alu_op;
            z_in    = 1'b1;
            state_d = ST_T5;
         end
         ST_T5: begin
            zlow_out = 1'b1;
            r_in     = ra_oh;
            cnt_d    = cnt_q + CNT_W'(1);
            state_d  = run ? ST_T0 : ST_IDLE;
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
   assign instr_count = cnt_q;

   // State and retired-instruction counter registers
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule : control_sequencer
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer. Expected output
//                vectors are pushed to a scoreboard as stimulus is applied and
//                compared against the DUT once it settles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

   typedef enum int {B_IDLE, B_T0, B_T1, B_T2, B_T3, B_T4, B_T5, B_HALT} bst_t;

   logic        clock = 1'b0;
   logic        clear, run, mem_ready;
   logic [31:0] ir;

   // Main instance (default parameters)
   logic        a_pc_out, a_mar_in, a_inc_pc, a_z_in, a_zlow_out, a_pc_in;
   logic        a_read, a_mdr_in, a_mdr_out, a_ir_in, a_y_in;
   logic [15:0] a_r_in, a_r_out, a_count;
   logic [2:0]  a_alu_op;
   logic        a_busy, a_halted, a_illegal;

   // Narrow-counter instance for wrap checks
   logic        b_pc_out, b_mar_in, b_inc_pc, b_z_in, b_zlow_out, b_pc_in;
   logic        b_read, b_mdr_in, b_mdr_out, b_ir_in, b_y_in;
   logic [15:0] b_r_in, b_r_out;
   logic [1:0]  b_count;
   logic [2:0]  b_alu_op;
   logic        b_busy, b_halted, b_illegal;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   logic [15:0] exp_cnt = '0;
   logic [65:0] sb_main[$];
   logic [1:0]  sb_small[$];

   always #5 clock = ~clock;

   control_sequencer #(.NUM_REGS(16), .OPCODE_W(5), .CNT_W(16)) u_dut (
      .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
      .pc_out(a_pc_out), .mar_in(a_mar_in), .inc_pc(a_inc_pc), .z_in(a_z_in),
      .zlow_out(a_zlow_out), .pc_in(a_pc_in), .read(a_read), .mdr_in(a_mdr_in),
      .mdr_out(a_mdr_out), .ir_in(a_ir_in), .y_in(a_y_in), .r_in(a_r_in),
      .r_out(a_r_out), .alu_op(a_alu_op), .busy(a_busy), .halted(a_halted),
      .illegal(a_illegal), .instr_count(a_count)
   );

   control_sequencer #(.NUM_REGS(16), .OPCODE_W(5), .CNT_W(2)) u_dut_w2 (
      .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
      .pc_out(b_pc_out), .mar_in(b_mar_in), .inc_pc(b_inc_pc), .z_in(b_z_in),
      .zlow_out(b_zlow_out), .pc_in(b_pc_in), .read(b_read), .mdr_in(b_mdr_in),
      .mdr_out(b_mdr_out), .ir_in(b_ir_in), .y_in(b_y_in), .r_in(b_r_in),
      .r_out(b_r_out), .alu_op(b_alu_op), .busy(b_busy), .halted(b_halted),
      .illegal(b_illegal), .instr_count(b_count)
   );

   task automatic check_val(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic is_alu(input logic [31:0] irv);
      return (irv[31:27] == 5'b00011) || (irv[31:27] == 5'b00100) ||
             (irv[31:27] == 5'b00101) || (irv[31:27] == 5'b00110);
   endfunction

   // Expected output vector for a given state, IR, mem_ready and count
   function automatic logic [65:0] exp_vec(input bst_t st, input logic [31:0] irv,
                                           input logic mr, input logic [15:0] cnt);
      logic [10:0] s;   // pc_out mar_in inc_pc z_in zlow_out pc_in read mdr_in mdr_out ir_in y_in
      logic [15:0] rin, rout, one;
      logic [2:0]  op;
      logic        bsy, hlt, ill;
      s = '0; rin = '0; rout = '0; op = 3'd0; ill = 1'b0;
      one = 16'd1;
      bsy = (st != B_IDLE) && (st != B_HALT);
      hlt = (st == B_HALT);
      case (st)
         B_T0: s = 11'b11110000000;
         B_T1: s = mr ? 11'b00001111000 : 11'b00000011000;
         B_T2: s = 11'b00000000110;
         B_T3: begin
            if (is_alu(irv)) begin
               s    = 11'b00000000001;
               rout = one << irv[22:19];
            end else if (irv[31:27] != 5'b00000 && irv[31:27] != 5'b11111) begin
               ill = 1'b1;
            end
         end
         B_T4: begin
            s    = 11'b00010000000;
            rout = one << irv[18:15];
            case (irv[31:27])
               5'b00011: op = 3'd1;
               5'b00100: op = 3'd2;
               5'b00101: op = 3'd3;
               5'b00110: op = 3'd4;
               default:  op = 3'd0;
            endcase
         end
         B_T5: begin
            s   = 11'b00001000000;
            rin = one << irv[26:23];
         end
         default: s = '0;
      endcase
      return {s, rin, rout, op, bsy, hlt, ill, cnt};
   endfunction

   // One clock of stimulus: push expectations, drive, settle, pop and compare
   task automatic step(input string tag, input bst_t st, input logic run_v,
                       input logic mr_v, input logic [31:0] ir_v, input logic clr_v);
      logic [65:0] got, exp_m;
      logic [1:0]  exp_s;
      @(negedge clock);
      cyc++;
      run = run_v; mem_ready = mr_v; ir = ir_v; clear = clr_v;
      sb_main.push_back(exp_vec(st, ir_v, mr_v, exp_cnt));
      sb_small.push_back(exp_cnt[1:0]);
      #1;
      got = {a_pc_out, a_mar_in, a_inc_pc, a_z_in, a_zlow_out, a_pc_in, a_read,
             a_mdr_in, a_mdr_out, a_ir_in, a_y_in, a_r_in, a_r_out, a_alu_op,
             a_busy, a_halted, a_illegal, a_count};
      exp_m = sb_main.pop_front();
      exp_s = sb_small.pop_front();
      check_val($sformatf("%s_c%0d", tag, cyc), got, exp_m);
      check_val($sformatf("%s_cnt2_c%0d", tag, cyc), {64'd0, b_count}, {64'd0, exp_s});
      if (clr_v)
         exp_cnt = '0;
      else if (st == B_T5 || (st == B_T3 && ir_v[31:27] == 5'b00000))
         exp_cnt = exp_cnt + 16'd1;
   endtask

   // One instruction starting in T0; run_mid drives the inner cycles, run_last the boundary
   task automatic do_instr(input string tag, input logic [31:0] ir_v, input int stall,
                           input logic run_mid, input logic run_last);
      logic alu;
      alu = is_alu(ir_v);
      step(tag, B_T0, 1'b1, 1'b0, ir_v, 1'b0);
      for (int i = 0; i < stall; i++) step(tag, B_T1, run_mid, 1'b0, ir_v, 1'b0);
      step(tag, B_T1, run_mid, 1'b1, ir_v, 1'b0);
      step(tag, B_T2, run_mid, 1'b0, ir_v, 1'b0);
      if (alu) begin
         step(tag, B_T3, run_mid, 1'b0, ir_v, 1'b0);
         step(tag, B_T4, run_mid, 1'b0, ir_v, 1'b0);
         step(tag, B_T5, run_last, 1'b0, ir_v, 1'b0);
      end else begin
         step(tag, B_T3, run_last, 1'b0, ir_v, 1'b0);
      end
   endtask

   function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      return {opc, ra, rb, rc, 15'd0};
   endfunction

   initial begin
      clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
      repeat (2) @(posedge clock);

      // Reset state
      step("reset", B_IDLE, 1'b0, 1'b0, 32'h0, 1'b0);
      step("idle",  B_IDLE, 1'b0, 1'b1, 32'h0, 1'b0);

      // AND r1 = r2 & r3
      step("go", B_IDLE, 1'b1, 1'b1, 32'h28918000, 1'b0);
      do_instr("and", 32'h28918000, 0, 1'b1, 1'b1);

      // ADD with a three-cycle memory stall
      do_instr("stall", mk_ir(5'b00011, 4'd5, 4'd7, 4'd9), 3, 1'b1, 1'b1);

      // SUB and OR cover the remaining ALU encodings
      do_instr("sub", mk_ir(5'b00100, 4'd15, 4'd0, 4'd14), 0, 1'b1, 1'b1);
      do_instr("or",  mk_ir(5'b00110, 4'd0, 4'd15, 4'd1), 1, 1'b1, 1'b1);

      // Illegal opcode then NOP
      do_instr("ill", 32'h50000000, 0, 1'b1, 1'b1);
      do_instr("nop", 32'h00000000, 0, 1'b1, 1'b1);

      // Clear while waiting on memory
      step("mwclr", B_T0, 1'b1, 1'b0, 32'h28918000, 1'b0);
      step("mwclr", B_T1, 1'b1, 1'b0, 32'h28918000, 1'b0);
      step("mwclr", B_T1, 1'b1, 1'b0, 32'h28918000, 1'b1);
      step("mwclr", B_IDLE, 1'b0, 1'b0, 32'h28918000, 1'b0);

      // Five NOPs: narrow counter wraps, run dropped inside the fifth
      step("wrap", B_IDLE, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) do_instr("wrap", 32'h0, 0, 1'b1, 1'b1);
      do_instr("wrap5", 32'h0, 0, 1'b0, 1'b0);
      step("wrap_end", B_IDLE, 1'b0, 1'b1, 32'h0, 1'b0);
      step("wrap_end", B_IDLE, 1'b0, 1'b1, 32'h0, 1'b0);

      // HALT holds regardless of run until clear
      step("halt", B_IDLE, 1'b1, 1'b1, 32'hF8000000, 1'b0);
      do_instr("halt", 32'hF8000000, 0, 1'b1, 1'b1);
      for (int k = 0; k < 20; k++) step("halted", B_HALT, k[0], 1'b1, 32'hF8000000, 1'b0);
      step("halt_clr", B_HALT, 1'b1, 1'b1, 32'hF8000000, 1'b1);
      step("halt_idle", B_IDLE, 1'b0, 1'b1, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_control_sequencer
`default_nettype wire
